// File: rtl/dispatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_ctrl_pkg
// Description : Shared defines for the dispatch controller: opcode constants
//               used for load/store classification, default structure sizes
//               and boolean constants.
// Revision    : 1.0 - initial release
// ============================================================================
package dispatch_ctrl_pkg;

  // Default entry counts for the downstream structures.
  localparam int DEF_ROB_SIZE = 16;
  localparam int DEF_RS_SIZE  = 16;
  localparam int DEF_LSB_SIZE = 16;

  // Major opcodes routed to the load/store buffer.
  localparam logic [6:0] OPCODE_L = 7'b0000011;
  localparam logic [6:0] OPCODE_S = 7'b0100011;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage : dispatch_ctrl_pkg
`default_nettype wire

// File: rtl/credit_counter.sv
`default_nettype none
// ============================================================================
// Module      : credit_counter
// Description : Free-credit counter for one downstream structure. Resets and
//               flushes to SIZE; each cycle applies -alloc +release. A
//               release arriving while already at SIZE is dropped, but an
//               allocation in the same cycle still takes effect.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               en            - global enable, low freezes the count
//               alloc         - one credit consumed this cycle
//               release_en    - one credit returned this cycle
//               flush         - return to SIZE (overrides alloc/release)
//               count         - current registered free-credit count
// Revision    : 1.0 - initial release
// ============================================================================
module credit_counter #(
  parameter  int SIZE = 16,
  localparam int W    = $clog2(SIZE) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         alloc,
  input  logic         release_en,
  input  logic         flush,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] c_FULL = W'(SIZE);
  localparam logic [W-1:0] c_ONE  = W'(1);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;
  logic         w_rel_ok;

  // A release at SIZE is a protocol error; drop it so the count saturates.
  assign w_rel_ok = release_en && (r_count != c_FULL);

  always_comb begin
    w_next = r_count;
    if (flush) begin
      w_next = c_FULL;
    end else begin
      if (alloc)    w_next = w_next - c_ONE;
      if (w_rel_ok) w_next = w_next + c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= c_FULL;
    end else if (en) begin
      r_count <= w_next;
    end
  end

  assign count = r_count;

endmodule : credit_counter
`default_nettype wire

// File: rtl/dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_ctrl
// Description : Dispatch stage controller. Classifies the instruction at the
//               queue head as load/store or not, pops it when the ROB and the
//               target structure (LSB or RS) both have free credits, and
//               issues a registered dispatch with the allocated ROB tag.
// Ports       : clk, rst                  - clock, sync active-high reset
//               rdy                       - global enable
//               iq_valid, iq_inst, iq_pop - instruction queue head handshake
//               rob/rs/lsb_release        - one entry freed downstream
//               roll_back                 - misprediction flush
//               dsp_valid, dsp_to_lsb,
//               dsp_rob_tag               - registered dispatch outputs
//               rob/rs/lsb_full           - free-credit count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter  int ROB_SIZE = DEF_ROB_SIZE,
  parameter  int RS_SIZE  = DEF_RS_SIZE,
  parameter  int LSB_SIZE = DEF_LSB_SIZE,
  localparam int TAG_W    = $clog2(ROB_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             iq_valid,
  input  logic [31:0]      iq_inst,
  output logic             iq_pop,
  input  logic             rob_release,
  input  logic             rs_release,
  input  logic             lsb_release,
  input  logic             roll_back,
  output logic             dsp_valid,
  output logic             dsp_to_lsb,
  output logic [TAG_W-1:0] dsp_rob_tag,
  output logic             rob_full,
  output logic             rs_full,
  output logic             lsb_full
);

  localparam int ROB_W = $clog2(ROB_SIZE) + 1;
  localparam int RS_W  = $clog2(RS_SIZE) + 1;
  localparam int LSB_W = $clog2(LSB_SIZE) + 1;

  localparam logic [TAG_W-1:0] c_TAG_ONE = TAG_W'(1);

  logic [ROB_W-1:0] w_rob_cred;
  logic [RS_W-1:0]  w_rs_cred;
  logic [LSB_W-1:0] w_lsb_cred;

  logic             w_is_ls;
  logic             w_target_ok;
  logic             w_unused_inst;

  logic [TAG_W-1:0] r_tag_ptr;
  logic             r_dsp_valid;
  logic             r_dsp_to_lsb;
  logic [TAG_W-1:0] r_dsp_rob_tag;

  // Only the major opcode matters for routing.
  assign w_unused_inst = &{1'b0, iq_inst[31:7]};

  assign w_is_ls     = (iq_inst[6:0] == OPCODE_L) || (iq_inst[6:0] == OPCODE_S);
  assign w_target_ok = w_is_ls ? (w_lsb_cred != '0) : (w_rs_cred != '0);
  assign iq_pop      = iq_valid && rdy && !roll_back && (w_rob_cred != '0) && w_target_ok;

  assign rob_full = (w_rob_cred == '0);
  assign rs_full  = (w_rs_cred  == '0);
  assign lsb_full = (w_lsb_cred == '0);

  // iq_pop already excludes roll_back, so flush naturally wins over alloc.
  credit_counter #(.SIZE(ROB_SIZE)) u_rob_cred (
    .clk        (clk),
    .rst        (rst),
    .en         (rdy),
    .alloc      (iq_pop),
    .release_en (rob_release),
    .flush      (roll_back),
    .count      (w_rob_cred)
  );

  credit_counter #(.SIZE(RS_SIZE)) u_rs_cred (
    .clk        (clk),
    .rst        (rst),
    .en         (rdy),
    .alloc      (iq_pop && !w_is_ls),
    .release_en (rs_release),
    .flush      (roll_back),
    .count      (w_rs_cred)
  );

  credit_counter #(.SIZE(LSB_SIZE)) u_lsb_cred (
    .clk        (clk),
    .rst        (rst),
    .en         (rdy),
    .alloc      (iq_pop && w_is_ls),
    .release_en (lsb_release),
    .flush      (roll_back),
    .count      (w_lsb_cred)
  );

  // ROB_SIZE is a power of two, so the tag pointer wraps by overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_ptr     <= '0;
      r_dsp_valid   <= FALSE;
      r_dsp_to_lsb  <= FALSE;
      r_dsp_rob_tag <= '0;
    end else if (rdy) begin
      if (roll_back) begin
        r_tag_ptr   <= '0;
        r_dsp_valid <= FALSE;
      end else begin
        r_dsp_valid <= iq_pop;
        if (iq_pop) begin
          r_dsp_to_lsb  <= w_is_ls;
          r_dsp_rob_tag <= r_tag_ptr;
          r_tag_ptr     <= r_tag_ptr + c_TAG_ONE;
        end
      end
    end
  end

  assign dsp_valid   = r_dsp_valid;
  assign dsp_to_lsb  = r_dsp_to_lsb;
  assign dsp_rob_tag = r_dsp_rob_tag;

endmodule : dispatch_ctrl
`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_ctrl
// Description : Self-checking bench for dispatch_ctrl. Directed scenarios plus
//               a randomized run, all checked against a credit-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_ctrl;

  localparam int ROB = 16;
  localparam int RS  = 16;
  localparam int LSB = 16;

  localparam logic [31:0] c_ALU   = 32'h0020_80b3;
  localparam logic [31:0] c_LOAD  = 32'h0000_a103;
  localparam logic [31:0] c_STORE = 32'h0020_a023;

  logic        clk = 1'b0;
  logic        rst, rdy, iq_valid, rob_release, rs_release, lsb_release, roll_back;
  logic [31:0] iq_inst;
  logic        iq_pop, dsp_valid, dsp_to_lsb, rob_full, rs_full, lsb_full;
  logic [3:0]  dsp_rob_tag;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_rob, m_rs, m_lsb, m_tag, m_dtag;
  bit m_dv, m_tl;

  always #5 clk = ~clk;

  dispatch_ctrl #(.ROB_SIZE(ROB), .RS_SIZE(RS), .LSB_SIZE(LSB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .iq_valid    (iq_valid),
    .iq_inst     (iq_inst),
    .iq_pop      (iq_pop),
    .rob_release (rob_release),
    .rs_release  (rs_release),
    .lsb_release (lsb_release),
    .roll_back   (roll_back),
    .dsp_valid   (dsp_valid),
    .dsp_to_lsb  (dsp_to_lsb),
    .dsp_rob_tag (dsp_rob_tag),
    .rob_full    (rob_full),
    .rs_full     (rs_full),
    .lsb_full    (lsb_full)
  );

  function automatic bit m_is_ls(input logic [31:0] inst);
    int op;
    op = int'(inst & 32'h7f);
    return (op == 3) || (op == 35);
  endfunction

  function automatic bit m_pop();
    bit ls;
    ls = m_is_ls(iq_inst);
    return iq_valid && rdy && !roll_back && (m_rob > 0) && (ls ? (m_lsb > 0) : (m_rs > 0));
  endfunction

  function automatic int sat_add(input int v, input int r, input int lim);
    return (v + r > lim) ? lim : v + r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic rr, input logic rsr,
                       input logic lr, input logic rb, input logic en, input logic rs_i);
    @(negedge clk);
    iq_valid = v; iq_inst = inst; rob_release = rr; rs_release = rsr;
    lsb_release = lr; roll_back = rb; rdy = en; rst = rs_i;
    #1;
  endtask

  // Advance one clock and step the model with the inputs held across the edge.
  task automatic tick();
    bit p, ls;
    p  = m_pop();
    ls = m_is_ls(iq_inst);
    @(posedge clk);
    #1;
    if (rst) begin
      m_rob = ROB; m_rs = RS; m_lsb = LSB; m_tag = 0;
      m_dv = 0; m_tl = 0; m_dtag = 0;
    end else if (rdy) begin
      if (roll_back) begin
        m_rob = ROB; m_rs = RS; m_lsb = LSB; m_tag = 0; m_dv = 0;
      end else begin
        m_dv = p;
        if (p) begin
          m_tl = ls; m_dtag = m_tag; m_tag = (m_tag + 1) % ROB;
        end
        m_rob = sat_add(m_rob, int'(rob_release), ROB) - int'(p);
        m_rs  = sat_add(m_rs,  int'(rs_release),  RS)  - int'(p && !ls);
        m_lsb = sat_add(m_lsb, int'(lsb_release), LSB) - int'(p && ls);
      end
    end
  endtask

  task automatic do_reset();
    drive(0, c_ALU, 0, 0, 0, 0, 1, 1);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (dsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dsp_valid: got %0b exp 0", dsp_valid); end
    n_tests++; if (dsp_to_lsb !== 1'b0) begin n_fail++; $display("FAIL reset_dsp_to_lsb: got %0b exp 0", dsp_to_lsb); end
    n_tests++; if (dsp_rob_tag !== 4'd0) begin n_fail++; $display("FAIL reset_dsp_rob_tag: got %0d exp 0", dsp_rob_tag); end
    n_tests++; if ({rob_full, rs_full, lsb_full} !== 3'b000) begin n_fail++; $display("FAIL reset_full: got %b exp 000", {rob_full, rs_full, lsb_full}); end
  endtask

  task automatic test_rob_fill();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, c_ALU, 0, 0, 0, 0, 1, 0);
      n_tests++; if (iq_pop !== (i < 16)) begin n_fail++; $display("FAIL fill_pop[%0d]: got %0b exp %0b", i, iq_pop, (i < 16)); end
      tick();
      if (i < 16) begin
        n_tests++; if (dsp_valid !== 1'b1 || dsp_rob_tag !== 4'(i)) begin n_fail++; $display("FAIL fill_tag[%0d]: got v=%0b tag=%0d exp v=1 tag=%0d", i, dsp_valid, dsp_rob_tag, i); end
      end else begin
        n_tests++; if (dsp_valid !== 1'b0) begin n_fail++; $display("FAIL fill_17th_valid: got %0b exp 0", dsp_valid); end
      end
    end
    n_tests++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL fill_rob_full: got %0b exp 1", rob_full); end
  endtask

  task automatic test_rob_wrap();
    drive(0, c_ALU, 1, 0, 0, 0, 1, 0);
    tick();
    n_tests++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL wrap_rob_full: got %0b exp 0", rob_full); end
    drive(1, c_LOAD, 0, 0, 0, 0, 1, 0);
    n_tests++; if (iq_pop !== 1'b1) begin n_fail++; $display("FAIL wrap_pop: got %0b exp 1", iq_pop); end
    tick();
    n_tests++; if (dsp_valid !== 1'b1 || dsp_rob_tag !== 4'd0 || dsp_to_lsb !== 1'b1) begin n_fail++; $display("FAIL wrap_tag: got v=%0b tag=%0d lsb=%0b exp v=1 tag=0 lsb=1", dsp_valid, dsp_rob_tag, dsp_to_lsb); end
  endtask

  task automatic test_lsb_same_cycle();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1, c_LOAD, 0, 0, 0, 0, 1, 0);
      tick();
    end
    drive(1, c_LOAD, 0, 0, 1, 0, 1, 0);
    n_tests++; if (iq_pop !== 1'b1) begin n_fail++; $display("FAIL lsb_same_pop: got %0b exp 1", iq_pop); end
    tick();
    n_tests++; if (lsb_full !== 1'b0 || rob_full !== 1'b1) begin n_fail++; $display("FAIL lsb_same_flags: got lsb_full=%0b rob_full=%0b exp 0 1", lsb_full, rob_full); end
    // Return one ROB credit; the single remaining LSB credit is then consumed.
    drive(0, c_LOAD, 1, 0, 0, 0, 1, 0);
    tick();
    drive(1, c_LOAD, 0, 0, 0, 0, 1, 0);
    tick();
    n_tests++; if (lsb_full !== 1'b1) begin n_fail++; $display("FAIL lsb_same_exact: got lsb_full=%0b exp 1", lsb_full); end
  endtask

  task automatic test_store_blocked();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, c_LOAD, 1, 0, 0, 0, 1, 0);
      tick();
    end
    n_tests++; if ({rob_full, rs_full, lsb_full} !== 3'b001) begin n_fail++; $display("FAIL blk_flags: got %b exp 001", {rob_full, rs_full, lsb_full}); end
    drive(1, c_STORE, 0, 0, 0, 0, 1, 0);
    n_tests++; if (iq_pop !== 1'b0) begin n_fail++; $display("FAIL blk_store_pop: got %0b exp 0", iq_pop); end
    drive(1, c_ALU, 0, 0, 0, 0, 1, 0);
    n_tests++; if (iq_pop !== 1'b1) begin n_fail++; $display("FAIL blk_alu_pop: got %0b exp 1", iq_pop); end
    tick();
    n_tests++; if (dsp_valid !== 1'b1 || dsp_to_lsb !== 1'b0 || dsp_rob_tag !== 4'd0) begin n_fail++; $display("FAIL blk_alu_dsp: got v=%0b lsb=%0b tag=%0d exp 1 0 0", dsp_valid, dsp_to_lsb, dsp_rob_tag); end
  endtask

  task automatic test_rollback();
    drive(1, c_ALU, 1, 0, 0, 1, 1, 0);
    n_tests++; if (iq_pop !== 1'b0) begin n_fail++; $display("FAIL rb_pop: got %0b exp 0", iq_pop); end
    tick();
    n_tests++; if (dsp_valid !== 1'b0 || {rob_full, rs_full, lsb_full} !== 3'b000) begin n_fail++; $display("FAIL rb_state: got v=%0b full=%b exp 0 000", dsp_valid, {rob_full, rs_full, lsb_full}); end
    drive(1, c_STORE, 0, 0, 0, 0, 1, 0);
    tick();
    n_tests++; if (dsp_valid !== 1'b1 || dsp_rob_tag !== 4'd0) begin n_fail++; $display("FAIL rb_tag: got v=%0b tag=%0d exp 1 0", dsp_valid, dsp_rob_tag); end
  endtask

  task automatic test_rdy_low();
    int t;
    drive(1, c_ALU, 0, 0, 0, 0, 1, 0);
    tick();
    t = m_tag;
    for (int i = 0; i < 3; i++) begin
      drive(1, c_ALU, 1, 1, 1, 1, 0, 0);
      n_tests++; if (iq_pop !== 1'b0) begin n_fail++; $display("FAIL rdy_pop[%0d]: got %0b exp 0", i, iq_pop); end
      tick();
      n_tests++; if (dsp_valid !== 1'b1) begin n_fail++; $display("FAIL rdy_frozen_valid[%0d]: got %0b exp 1", i, dsp_valid); end
    end
    drive(1, c_ALU, 0, 0, 0, 0, 1, 0);
    tick();
    n_tests++; if (dsp_valid !== 1'b1 || dsp_rob_tag !== 4'(t)) begin n_fail++; $display("FAIL rdy_resume: got v=%0b tag=%0d exp 1 %0d", dsp_valid, dsp_rob_tag, t); end
  endtask

  task automatic test_midstream_rst();
    drive(1, c_LOAD, 0, 0, 0, 0, 1, 1);
    tick();
    n_tests++; if (dsp_valid !== 1'b0 || dsp_rob_tag !== 4'd0 || dsp_to_lsb !== 1'b0) begin n_fail++; $display("FAIL mid_rst: got v=%0b tag=%0d lsb=%0b exp 0 0 0", dsp_valid, dsp_rob_tag, dsp_to_lsb); end
  endtask

  task automatic test_random();
    logic [31:0] inst;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      inst = $urandom;
      case ($urandom_range(0, 3))
        0: inst[6:0] = 7'b0000011;
        1: inst[6:0] = 7'b0100011;
        2: inst[6:0] = 7'b0110011;
        default: ;
      endcase
      drive($urandom_range(0, 9) < 8, inst, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 99) == 0);
      n_tests++; if (iq_pop !== m_pop()) begin n_fail++; $display("FAIL rnd_pop[%0d]: got %0b exp %0b", i, iq_pop, m_pop()); end
      n_tests++; if ({rob_full, rs_full, lsb_full} !== {m_rob == 0, m_rs == 0, m_lsb == 0}) begin n_fail++; $display("FAIL rnd_full[%0d]: got %b exp %b", i, {rob_full, rs_full, lsb_full}, {m_rob == 0, m_rs == 0, m_lsb == 0}); end
      tick();
      n_tests++; if (dsp_valid !== m_dv || dsp_to_lsb !== m_tl || dsp_rob_tag !== 4'(m_dtag)) begin n_fail++; $display("FAIL rnd_dsp[%0d]: got v=%0b lsb=%0b tag=%0d exp v=%0b lsb=%0b tag=%0d", i, dsp_valid, dsp_to_lsb, dsp_rob_tag, m_dv, m_tl, m_dtag); end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; iq_valid = 1'b0; iq_inst = c_ALU;
    rob_release = 1'b0; rs_release = 1'b0; lsb_release = 1'b0; roll_back = 1'b0;
    m_rob = ROB; m_rs = RS; m_lsb = LSB; m_tag = 0; m_dtag = 0; m_dv = 0; m_tl = 0;
    test_reset();
    test_rob_fill();
    test_rob_wrap();
    test_lsb_same_cycle();
    test_store_blocked();
    test_rollback();
    test_rdy_low();
    test_midstream_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dispatch_ctrl
`default_nettype wire

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 Parameter ROB_SIZE, default 16, ROB entry count (power of two, at most 32).
REQ-002 Parameter RS_SIZE, default 16, reservation-station entry count.
REQ-003 Parameter LSB_SIZE, default 16, load/store-buffer entry count.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rdy  in  1  global enable; low freezes all state.
REQ-007 iq_valid  in  1  instruction-queue head holds an instruction.
REQ-008 iq_inst  in  32  instruction word at the queue head.
REQ-009 iq_pop  out  1  combinational; the queue head is consumed this cycle.
REQ-010 rob_release  in  1  ROB retired one entry this cycle.
REQ-011 rs_release  in  1  RS freed one entry this cycle.
REQ-012 lsb_release  in  1  LSB freed one entry this cycle.
REQ-013 roll_back  in  1  misprediction flush.
REQ-014 dsp_valid  out  1  registered; an instruction was dispatched.
REQ-015 dsp_to_lsb  out  1  registered; the target is LSB (otherwise RS).
REQ-016 dsp_rob_tag  out  log2(ROB_SIZE)  registered; allocated ROB index.
REQ-017 rob_full, rs_full, lsb_full  out  1 each  combinational; the free-credit count is 0.

Function
REQ-018 The block SHALL hold the free-credit counters rob_cred, rs_cred and lsb_cred, each log2(SIZE)+1 bits wide, plus a tag pointer tag_ptr.
REQ-019 Classification SHALL be: opcode iq_inst[6:0] equal to 0000011 (load) or 0100011 (store) gives is_ls=1; every other opcode gives is_ls=0.
REQ-020 iq_pop SHALL equal iq_valid AND rdy AND NOT roll_back AND rob_cred!=0 AND (is_ls ? lsb_cred!=0 : rs_cred!=0).
REQ-021 On iq_pop, at the next edge:
- dsp_valid SHALL be 1, dsp_to_lsb SHALL be is_ls, and dsp_rob_tag SHALL be tag_ptr.
- tag_ptr SHALL increment, wrapping from ROB_SIZE-1 to 0.
REQ-022 Without iq_pop, dsp_valid SHALL be 0 at the next edge, and dsp_to_lsb and dsp_rob_tag SHALL hold their values.
REQ-023 Each counter SHALL update as next = cred - alloc + release.
- A simultaneous alloc and release SHALL leave the counter unchanged.
REQ-024 A release while a counter already equals its SIZE (protocol error) SHALL saturate the counter at SIZE.
- If an alloc occurs in the same cycle, the alloc SHALL still apply.
REQ-025 Full flags SHALL reflect the current registered counters, so dispatch latency is one cycle and releases take effect the cycle after they are asserted.
REQ-026 On roll_back with rdy high, at the next edge:
- all counters SHALL return to SIZE and tag_ptr SHALL return to 0.
- dsp_valid SHALL be 0.
- same-cycle releases SHALL be ignored.
REQ-027 With rdy low, the block SHALL change no state and SHALL hold iq_pop at 0.
REQ-028 roll_back SHALL take priority over dispatch and release.
REQ-029 rst SHALL take priority over roll_back and rdy.

Reset
REQ-030 On rst, at the edge:
- rob_cred=ROB_SIZE, rs_cred=RS_SIZE, lsb_cred=LSB_SIZE.
- tag_ptr=0, dsp_valid=0, dsp_to_lsb=0, dsp_rob_tag=0.
REQ-031 An rst asserted mid-stream SHALL discard any in-flight dispatch, so dsp_valid=0 in the cycle after rst.

Structure
REQ-032 Opcode constants (OPCODE_L, OPCODE_S), the default SIZE values and the True/False constants SHALL live in the shared defines package.
REQ-033 One sub-module, credit_counter, SHALL be used, parameterized by SIZE with ports alloc, release, flush and a count output; it SHALL be instantiated three times.
REQ-034 Classification and iq_pop SHALL be pure combinational logic in dispatch_ctrl.

Verification
REQ-035 Reset, then 17 consecutive ALU ops with iq_valid=1 -> 16 dispatches with tags 0..15, then rob_full=1 and iq_pop=0 on the 17th.
REQ-036 rob_cred=0, then assert rob_release one cycle -> iq_pop=1 the following cycle and dsp_rob_tag=0 (wrapped).
REQ-037 lsb_cred=1 and a load dispatched with lsb_release in the same cycle -> lsb_cred stays 1 and lsb_full stays 0.
REQ-038 Store at head with lsb_full=1 and rs_cred=16 -> iq_pop=0; an ALU op at head in the same state -> iq_pop=1 and dsp_to_lsb=0.
REQ-039 roll_back with iq_valid=1 and rob_release=1 -> iq_pop=0, then next cycle all counters equal SIZE, tag_ptr=0 and dsp_valid=0.
REQ-040 rdy=0 for 3 cycles with iq_valid=1 -> no pop and counters unchanged; rdy=1 -> dispatch resumes with the unchanged tag.
